register_file: RTL and testbench

// - 32 x 64-bit architectural register file for the single-cycle (unicycle) LEGv8 datapath.
// - Sits directly upstream of the ALU-source 64-bit 2:1 mux.
//   - readData2 drives that mux's inputA.
//   - The sign-extended immediate drives its inputB.
//   - readData1 feeds the ALU A operand directly.
// - Write-back (ALU result or memory data) returns on writeData at the end of each instruction cycle.
//

---
 rtl/register_file_pkg.sv | 13 +
 rtl/register_file.sv | 55 +++++
 tb/tb_register_file.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/register_file_pkg.sv
// Processor-wide constants shared by the register file,
// the ALU-source mux, the ALU and the control unit.
package register_file_pkg;

    localparam int DATA_WIDTH     = 64;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int NUM_REGS       = 32;
    localparam int XZR_INDEX      = 31;

    typedef logic [DATA_WIDTH-1:0]     regData_t;
    typedef logic [REG_ADDR_WIDTH-1:0] regAddr_t;

endpackage

// File: rtl/register_file.sv
// 32 x 64-bit LEGv8 register file: two combinational read
// ports and one synchronous write port, XZR hard-wired to 0.
module register_file
    import register_file_pkg::*;
#(
    parameter int DATA_WIDTH = register_file_pkg::DATA_WIDTH,
    parameter int NUM_REGS   = register_file_pkg::NUM_REGS,
    parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
    parameter int ZERO_REG   = XZR_INDEX
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] readReg1,
    input  logic [ADDR_WIDTH-1:0] readReg2,
    input  logic [ADDR_WIDTH-1:0] writeReg,
    input  logic [DATA_WIDTH-1:0] writeData,
    input  logic                  regWrite,
    output logic [DATA_WIDTH-1:0] readData1,
    output logic [DATA_WIDTH-1:0] readData2
);

    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR =
        ADDR_WIDTH'(ZERO_REG);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic                  writeEnable;

    assign writeEnable = regWrite && (writeReg != ZERO_ADDR);

    // No bypass: a same-cycle read sees the pre-edge value.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (writeEnable) begin
            regs[writeReg] <= writeData;
        end
    end

    function automatic logic [DATA_WIDTH-1:0] readPort(
        input logic [ADDR_WIDTH-1:0] addr
    );
        if (addr == ZERO_ADDR) begin
            return '0;
        end
        return regs[addr];
    endfunction

    always_comb begin
        readData1 = readPort(readReg1);
        readData2 = readPort(readReg2);
    end

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: expected read data is
// queued when reads are driven and popped when sampled.
module tb_register_file;

    import register_file_pkg::*;

    logic     clk;
    logic     reset;
    regAddr_t readReg1;
    regAddr_t readReg2;
    regAddr_t writeReg;
    regData_t writeData;
    logic     regWrite;
    regData_t readData1;
    regData_t readData2;

    register_file dut (
        .clk       (clk),
        .reset     (reset),
        .readReg1  (readReg1),
        .readReg2  (readReg2),
        .writeReg  (writeReg),
        .writeData (writeData),
        .regWrite  (regWrite),
        .readData1 (readData1),
        .readData2 (readData2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string    tag;
        bit       port2;
        regData_t exp;
    } sbItem_t;

    sbItem_t  sbQueue[$];
    regData_t model [NUM_REGS];
    int       compared;
    int       mismatched;

    task automatic checkVal(
        input string    tag,
        input regData_t got,
        input regData_t exp
    );
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h",
                     tag, got, exp);
        end
    endtask

    function automatic regData_t modelRead(input int idx);
        if (idx == XZR_INDEX) return '0;
        return model[idx];
    endfunction

    // Drive both read indices, queue expectations, then sample.
    task automatic readCheck(
        input string tag,
        input int    r1,
        input int    r2
    );
        sbItem_t item;
        readReg1 = regAddr_t'(r1);
        readReg2 = regAddr_t'(r2);
        item.tag   = {tag, "/rd1"};
        item.port2 = 1'b0;
        item.exp   = modelRead(r1);
        sbQueue.push_back(item);
        item.tag   = {tag, "/rd2"};
        item.port2 = 1'b1;
        item.exp   = modelRead(r2);
        sbQueue.push_back(item);
        #1;
        while (sbQueue.size() > 0) begin
            item = sbQueue.pop_front();
            checkVal(item.tag,
                     item.port2 ? readData2 : readData1,
                     item.exp);
        end
    endtask

    // One rising edge; the model samples the same inputs.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
        end else if (regWrite && writeReg != regAddr_t'(XZR_INDEX)) begin
            model[writeReg] = writeData;
        end
        #1;
    endtask

    task automatic doWrite(
        input int       addr,
        input regData_t data,
        input logic     en
    );
        writeReg  = regAddr_t'(addr);
        writeData = data;
        regWrite  = en;
        tick();
        regWrite  = 1'b0;
    endtask

    task automatic checkAll(input string tag);
        for (int i = 0; i < NUM_REGS; i++) begin
            readCheck($sformatf("%s[%0d]", tag, i), i,
                      NUM_REGS - 1 - i);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        for (int i = 0; i < NUM_REGS; i++) model[i] = 'x;
        reset     = 1'b1;
        regWrite  = 1'b0;
        writeReg  = '0;
        writeData = '0;
        readReg1  = '0;
        readReg2  = '0;
        @(negedge clk);
        tick();
        readCheck("heldReset", 12, 31);
        tick();
        reset = 1'b0;
        checkAll("afterReset");

        doWrite(5, 64'hDEAD_BEEF, 1'b1);
        readCheck("x5Written", 5, 5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        readCheck("x5Cleared", 5, 0);
        checkAll("resetAll");

        doWrite(3, 64'h0123_4567_89AB_CDEF, 1'b1);
        readCheck("basicRW", 3, 3);

        doWrite(31, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        readCheck("xzrWrite", 0, 31);
        checkAll("xzrNoSideEffect");

        doWrite(7, 64'h10, 1'b1);
        doWrite(7, 64'h20, 1'b0);
        readCheck("writeDisabled", 7, 7);

        doWrite(9, 64'h1, 1'b1);
        writeReg  = 5'd9;
        writeData = 64'h2;
        regWrite  = 1'b1;
        readCheck("rdwBefore", 9, 3);
        tick();
        regWrite  = 1'b0;
        readCheck("rdwAfter", 9, 9);

        doWrite(4, 64'h55, 1'b1);
        reset = 1'b1;
        doWrite(4, 64'hAA, 1'b1);
        readCheck("collisionHeld", 4, 9);
        reset = 1'b0;
        readCheck("collision", 4, 4);
        doWrite(4, 64'hBB, 1'b1);
        readCheck("firstWriteAfterReset", 4, 30);

        for (int n = 0; n < 40; n++) begin
            doWrite($urandom_range(0, 31),
                    {$urandom, $urandom},
                    1'($urandom_range(0, 1)));
            readCheck($sformatf("random%0d", n),
                      $urandom_range(0, 31),
                      $urandom_range(0, 31));
        end
        checkAll("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
